// File: rtl/rx_burst.sv
// rx_burst: receive-side burst detector and PRBS symbol scorer.
// Detects burst energy on the I/Q stream with on/off hysteresis, skips the
// transmitter ramp-up, then compares demodulated symbols against a local copy
// of the transmit PRBS and reports the per-burst symbol-error count.
`timescale 1ns/1ps
module rx_burst (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample_strobe,
  input  logic [8:0] rfchain_inphase,
  input  logic [8:0] rfchain_quadrature,
  input  logic       demod_symbol,
  input  logic       demod_strobe,
  input  logic       arm,
  input  logic       resync,
  output logic       is_armed,
  output logic       burst_active,
  output logic       burst_done,
  output logic       burst_aborted,
  output logic [7:0] symbol_errors,
  output logic [7:0] symbols_scored,
  output logic [9:0] energy
);

  localparam logic [9:0] ON_THRESH    = 10'd96;
  localparam logic [9:0] OFF_THRESH   = 10'd48;
  localparam logic [3:0] DETECT_LAST  = 4'd7;    // 8th consecutive "on" sample
  localparam logic [4:0] DROP_LAST    = 5'd15;   // 16th consecutive "off" sample
  localparam logic [8:0] SETTLE_LAST  = 9'd489;  // 490th settle sample
  localparam logic [1:0] SKIP_LAST    = 2'd1;    // 2nd skipped symbol
  localparam logic [7:0] PAYLOAD_LAST = 8'd13;   // 14th scored symbol
  localparam logic [7:0] LFSR_SEED    = 8'h01;
  localparam logic [7:0] LFSR_TAPS    = 8'h8e;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    ARMED  = 6'b000010,
    SETTLE = 6'b000100,
    SKIP   = 6'b001000,
    CHECK  = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  state_t      state;
  logic        sample_valid;
  logic [3:0]  on_run;
  logic [4:0]  off_run;
  logic [8:0]  settle_cnt;
  logic [1:0]  skip_cnt;
  logic [7:0]  err_cnt;
  logic [7:0]  scored_cnt;
  logic [7:0]  lfsr;

  logic        sample_on;
  logic        sample_off;
  logic        in_burst;
  logic        detect;
  logic        drop;
  logic        check_strobe;
  logic        final_symbol;
  logic        finish;
  logic [7:0]  err_next;
  logic [7:0]  scored_next;
  logic [7:0]  lfsr_step;
  logic [9:0]  energy_sum;

  // Magnitude of a 9-bit two's-complement value; -256 maps to 256.
  function automatic logic [8:0] magnitude(input logic [8:0] v);
    magnitude = v[8] ? (~v + 9'd1) : v;
  endfunction

  // One step of the Galois PRBS shared with the transmitter.
  function automatic logic [7:0] prbs_next(input logic [7:0] v);
    prbs_next = {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

  assign energy_sum = {1'b0, magnitude(rfchain_inphase)} + {1'b0, magnitude(rfchain_quadrature)};

  // Register sample energy and remember that a fresh value is present.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      energy       <= 10'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_strobe;
      if (sample_strobe) begin
        energy <= energy_sum;
      end else begin
        energy <= energy;
      end
    end
  end

  // Threshold decisions, FSM event qualifiers and next scoring values.
  always_comb begin
    sample_on    = 1'b0;
    sample_off   = 1'b0;
    if (sample_valid) begin
      sample_on  = (energy >= ON_THRESH);
      sample_off = (energy < OFF_THRESH);
    end else begin
      sample_on  = 1'b0;
      sample_off = 1'b0;
    end
    in_burst     = (state == SETTLE) || (state == SKIP) || (state == CHECK);
    detect       = (state == ARMED) && sample_on && (on_run == DETECT_LAST);
    drop         = in_burst && sample_off && (off_run == DROP_LAST);
    check_strobe = (state == CHECK) && demod_strobe;
    final_symbol = check_strobe && (scored_cnt == PAYLOAD_LAST);
    finish       = final_symbol || drop;
    lfsr_step    = prbs_next(lfsr);
    if (check_strobe && (demod_symbol != lfsr[1]) && (err_cnt != 8'hff)) begin
      err_next = err_cnt + 8'd1;
    end else begin
      err_next = err_cnt;
    end
    if (check_strobe) begin
      scored_next = scored_cnt + 8'd1;
    end else begin
      scored_next = scored_cnt;
    end
  end

  // Run lengths of consecutive strobed "on" (while armed) and "off" (in burst) samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      on_run  <= 4'd0;
      off_run <= 5'd0;
    end else begin
      if (state != ARMED) begin
        on_run <= 4'd0;
      end else if (sample_valid) begin
        on_run <= sample_on ? on_run + 4'd1 : 4'd0;
      end else begin
        on_run <= on_run;
      end
      if (!in_burst) begin
        off_run <= 5'd0;
      end else if (sample_valid) begin
        off_run <= sample_off ? off_run + 5'd1 : 5'd0;
      end else begin
        off_run <= off_run;
      end
    end
  end

  // Burst FSM with PRBS tracking, scoring counters and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lfsr           <= LFSR_SEED;
      settle_cnt     <= 9'd0;
      skip_cnt       <= 2'd0;
      err_cnt        <= 8'd0;
      scored_cnt     <= 8'd0;
      is_armed       <= 1'b0;
      burst_active   <= 1'b0;
      burst_done     <= 1'b0;
      burst_aborted  <= 1'b0;
      symbol_errors  <= 8'd0;
      symbols_scored <= 8'd0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          burst_active <= 1'b0;
          if (resync) lfsr <= LFSR_SEED;
          if (arm) begin
            state    <= ARMED;
            is_armed <= 1'b1;
          end else begin
            state    <= IDLE;
            is_armed <= 1'b0;
          end
        end
        ARMED: begin
          // A resync coinciding with detect still reloads before SETTLE.
          if (resync) lfsr <= LFSR_SEED;
          if (!arm) begin
            state    <= IDLE;
            is_armed <= 1'b0;
          end else if (detect) begin
            state        <= SETTLE;
            is_armed     <= 1'b0;
            burst_active <= 1'b1;
            settle_cnt   <= 9'd0;
            skip_cnt     <= 2'd0;
            err_cnt      <= 8'd0;
            scored_cnt   <= 8'd0;
          end else begin
            state    <= ARMED;
            is_armed <= 1'b1;
          end
        end
        SETTLE: begin
          // Demod strobes are ignored here: the ramp-up carries no payload.
          if (sample_valid) begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= SKIP;
            end else begin
              settle_cnt <= settle_cnt + 9'd1;
            end
          end
        end
        SKIP: begin
          if (demod_strobe) begin
            lfsr     <= lfsr_step;
            skip_cnt <= skip_cnt + 2'd1;
            if (skip_cnt == SKIP_LAST) state <= CHECK;
          end
        end
        CHECK: begin
          if (demod_strobe) lfsr <= lfsr_step;
          err_cnt    <= err_next;
          scored_cnt <= scored_next;
        end
        DONE: begin
          burst_active <= 1'b0;
          if (arm) begin
            state    <= ARMED;
            is_armed <= 1'b1;
          end else begin
            state    <= IDLE;
            is_armed <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          is_armed     <= 1'b0;
          burst_active <= 1'b0;
        end
      endcase
      // Completion or abort overrides the per-state transition; a final
      // symbol scored on the abort cycle counts as completion.
      if (finish) begin
        state          <= DONE;
        burst_active   <= 1'b0;
        burst_done     <= 1'b1;
        burst_aborted  <= !final_symbol;
        symbol_errors  <= err_next;
        symbols_scored <= scored_next;
      end
    end
  end

endmodule
